// File: rtl/wb_fwd_pipe_pkg.sv
// Shared constants and stage-update helper for the write-back forwarding pipeline.
// Optional statistics output is enabled with WB_FWD_PIPE_STATS_EN.
package wb_fwd_pipe_pkg;

    localparam int REG_BUS_W         = 32;
    localparam int REG_ADDR_BUS_W    = 5;
    localparam int WB_STAGES_DEFAULT = 2;
    localparam int RD_PORTS_DEFAULT  = 2;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_HOLD,
        ACT_BUBBLE
    } stage_act_e;

    // Flush beats hold, hold beats an upstream stall, otherwise take the source.
    function automatic stage_act_e stage_action(input logic flush, input logic hold,
                                                input logic src_stalled);
        if (flush)            return ACT_BUBBLE;
        else if (hold)        return ACT_HOLD;
        else if (src_stalled) return ACT_BUBBLE;
        else                  return ACT_LOAD;
    endfunction

endpackage

// File: rtl/wb_fwd_pipe_if.sv
// EX-result input and regfile write-back output bundle of the forwarding pipeline.
interface wb_fwd_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_we;
    logic [ADDR_W-1:0] in_waddr;
    logic [DATA_W-1:0] in_wdata;
    logic              in_stall;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;

    modport master (
        output in_we, in_waddr, in_wdata, in_stall,
        input  wb_we, wb_waddr, wb_wdata
    );

    modport slave (
        input  in_we, in_waddr, in_wdata, in_stall,
        output wb_we, wb_waddr, wb_wdata
    );
endinterface

// File: rtl/wb_fwd_pipe_stage_reg.sv
// One write-back stage register: flush, hold, bubble or load on each edge.
module wb_stage_reg
    import wb_fwd_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              src_stalled,
    input  logic              src_we,
    input  logic [ADDR_W-1:0] src_waddr,
    input  logic [DATA_W-1:0] src_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    stage_act_e act;

    assign act = stage_action(flush, hold, src_stalled);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we    <= WRITE_DISABLE;
            waddr <= '0;
            wdata <= '0;
        end else begin
            case (act)
                ACT_BUBBLE: begin
                    we    <= WRITE_DISABLE;
                    waddr <= '0;
                    wdata <= '0;
                end
                ACT_LOAD: begin
                    we    <= src_we;
                    waddr <= src_waddr;
                    wdata <= src_wdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_fwd_pipe.sv
// Parametrised write-back pipeline with youngest-first operand bypass.
// Defining WB_FWD_PIPE_STATS_EN adds the saturating fwd_hits counter output.
module wb_fwd_pipe
    import wb_fwd_pipe_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int ADDR_W   = REG_ADDR_BUS_W,
    parameter int STAGES   = WB_STAGES_DEFAULT,
    parameter int RD_PORTS = RD_PORTS_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    wb_fwd_pipe_if.slave                 bus,
    input  logic [STAGES-1:0]            stall,
    input  logic                         flush,
    input  logic [RD_PORTS-1:0]          rd_re,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    input  logic [RD_PORTS*DATA_W-1:0]   rd_regdata,
`ifdef WB_FWD_PIPE_STATS_EN
    output logic [31:0]                  fwd_hits,
`endif
    output logic [RD_PORTS*DATA_W-1:0]   rd_data
);

    logic              st_we    [STAGES];
    logic [ADDR_W-1:0] st_waddr [STAGES];
    logic [DATA_W-1:0] st_wdata [STAGES];
    logic [RD_PORTS-1:0] port_hit;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            wb_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stage (
                .clk(clk), .rst(rst), .flush(flush), .hold(stall[k]),
                .src_stalled(bus.in_stall), .src_we(bus.in_we),
                .src_waddr(bus.in_waddr), .src_wdata(bus.in_wdata),
                .we(st_we[k]), .waddr(st_waddr[k]), .wdata(st_wdata[k])
            );
        end else begin : g_next
            wb_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stage (
                .clk(clk), .rst(rst), .flush(flush), .hold(stall[k]),
                .src_stalled(stall[k-1]), .src_we(st_we[k-1]),
                .src_waddr(st_waddr[k-1]), .src_wdata(st_wdata[k-1]),
                .we(st_we[k]), .waddr(st_waddr[k]), .wdata(st_wdata[k])
            );
        end
    end

    assign bus.wb_we    = st_we[STAGES-1];
    assign bus.wb_waddr = st_waddr[STAGES-1];
    assign bus.wb_wdata = st_wdata[STAGES-1];

    // Oldest source is evaluated first so younger matches overwrite it; r0 never forwards.
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] fwd_val;
        logic              hit;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            hit     = 1'b0;
            fwd_val = '0;
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (st_we[k] && st_waddr[k] == addr) begin
                    hit     = 1'b1;
                    fwd_val = st_wdata[k];
                end
            end
            if (bus.in_we && !bus.in_stall && bus.in_waddr == addr) begin
                hit     = 1'b1;
                fwd_val = bus.in_wdata;
            end
            if (!rd_re[p] || addr == '0) begin
                hit     = 1'b0;
                fwd_val = '0;
            end
        end

        assign port_hit[p] = hit;
        assign rd_data[p*DATA_W +: DATA_W] =
            (!rd_re[p] || addr == '0) ? '0 :
            (hit ? fwd_val : rd_regdata[p*DATA_W +: DATA_W]);
    end

`ifdef WB_FWD_PIPE_STATS_EN
    logic [32:0] hits_next;
    logic [31:0] hits_inc;

    always_comb begin
        hits_inc = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            hits_inc = hits_inc + 32'(port_hit[p]);
        end
        hits_next = {1'b0, fwd_hits} + {1'b0, hits_inc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fwd_hits <= '0;
        else      fwd_hits <= hits_next[32] ? '1 : hits_next[31:0];
    end
`else
    logic unused_hits;
    assign unused_hits = ^port_hit;
`endif

endmodule

// File: tb/tb_wb_fwd_pipe.sv
// Directed self-checking bench for wb_fwd_pipe (STAGES=2, RD_PORTS=2).
module tb_wb_fwd_pipe;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int NP = 2;

    logic             clk;
    logic             rst;
    logic [NS-1:0]    stall;
    logic             flush;
    logic [NP-1:0]    rd_re;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_regdata;
    logic [NP*DW-1:0] rd_data;
`ifdef WB_FWD_PIPE_STATS_EN
    logic [31:0]      fwd_hits;
    logic [31:0]      hits_before;
`endif

    int errors = 0;
    int checks = 0;

    wb_fwd_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_fwd_pipe #(.DATA_W(DW), .ADDR_W(AW), .STAGES(NS), .RD_PORTS(NP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .stall(stall),
        .flush(flush),
        .rd_re(rd_re),
        .rd_addr(rd_addr),
        .rd_regdata(rd_regdata),
`ifdef WB_FWD_PIPE_STATS_EN
        .fwd_hits(fwd_hits),
`endif
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        check({tag, ".we"},    32'(bus.wb_we),    32'(we));
        check({tag, ".waddr"}, 32'(bus.wb_waddr), 32'(a));
        check({tag, ".wdata"}, bus.wb_wdata,      d);
    endtask

    task automatic set_in(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic st);
        bus.in_we    = we;
        bus.in_waddr = a;
        bus.in_wdata = d;
        bus.in_stall = st;
    endtask

    initial begin
        rst        = 1'b0;
        stall      = '0;
        flush      = 1'b0;
        rd_re      = '0;
        rd_addr    = '0;
        rd_regdata = '0;
        set_in(1'b0, '0, '0, 1'b0);
        #2;
        check_wb("reset_init", 1'b0, 5'd0, 32'h0);
        tick();
        rst = 1'b1;
`ifdef WB_FWD_PIPE_STATS_EN
        check("hits_reset", fwd_hits, 32'h0);
`endif

        // Latency: one write reaches wb_* after exactly two edges.
        set_in(1'b1, 5'd5, 32'h1234, 1'b0);
        tick();
        set_in(1'b0, '0, '0, 1'b0);
        check("lat_edge1.we", 32'(bus.wb_we), 32'h0);
        tick();
        check_wb("lat_edge2", 1'b1, 5'd5, 32'h1234);
        tick();
        check("lat_edge3.we", 32'(bus.wb_we), 32'h0);

        // Priority: EX result beats stage 0, stage 0 beats regfile.
        set_in(1'b1, 5'd3, 32'hB, 1'b0);
        tick();
        set_in(1'b1, 5'd3, 32'hA, 1'b0);
        rd_re      = 2'b11;
        rd_addr    = {5'd3, 5'd3};
        rd_regdata = {32'hC, 32'hC};
        #1;
        check("prio_in.p0", rd_data[31:0], 32'hA);
        check("prio_in.p1", rd_data[63:32], 32'hA);
        bus.in_stall = 1'b1;
        #1;
        check("prio_st0", rd_data[31:0], 32'hB);
        rd_addr = {5'd3, 5'd7};
        #1;
        check("prio_regfile", rd_data[31:0], 32'hC);
        check("prio_port1", rd_data[63:32], 32'hB);
        rd_re = 2'b10;
        #1;
        check("prio_re_off", rd_data[31:0], 32'h0);

        // Last stage still forwards while its write lands in the regfile.
        set_in(1'b0, '0, '0, 1'b0);
        rd_re   = 2'b01;
        rd_addr = {5'd0, 5'd3};
        tick();
        check_wb("last_stage", 1'b1, 5'd3, 32'hB);
        check("last_fwd", rd_data[31:0], 32'hB);
        tick();

        // Stall stage 0 for three cycles; stage 1 must receive bubbles.
        set_in(1'b1, 5'd9, 32'h99, 1'b0);
        tick();
        stall = 2'b01;
        set_in(1'b1, 5'd10, 32'hAA, 1'b1);
        rd_addr    = {5'd0, 5'd9};
        rd_regdata = {32'hC, 32'h5};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_bubble.we", 32'(bus.wb_we), 32'h0);
            check("stall_held", rd_data[31:0], 32'h99);
        end
        stall = 2'b00;
        set_in(1'b0, '0, '0, 1'b0);
        tick();
        check_wb("stall_release", 1'b1, 5'd9, 32'h99);

        // Flush with both stages valid and fully stalled.
        set_in(1'b1, 5'd1, 32'h11, 1'b0);
        tick();
        set_in(1'b1, 5'd2, 32'h22, 1'b0);
        tick();
        check_wb("pre_flush", 1'b1, 5'd1, 32'h11);
        set_in(1'b0, '0, '0, 1'b1);
        stall      = 2'b11;
        rd_re      = 2'b11;
        rd_addr    = {5'd1, 5'd2};
        rd_regdata = {32'h66, 32'h55};
        #1;
        check("pre_flush_fwd", rd_data[31:0], 32'h22);
        flush = 1'b1;
        tick();
        check("flush.we", 32'(bus.wb_we), 32'h0);
        check("flush_fb.p0", rd_data[31:0], 32'h55);
        check("flush_fb.p1", rd_data[63:32], 32'h66);

        // Flush drops a simultaneous EX write.
        stall = 2'b00;
        set_in(1'b1, 5'd4, 32'h44, 1'b0);
        tick();
        flush = 1'b0;
        set_in(1'b0, '0, '0, 1'b0);
        tick();
        check("flush_drop.we", 32'(bus.wb_we), 32'h0);

        // Register 0 is written down the pipe but never forwarded.
        set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        rd_re      = 2'b11;
        rd_addr    = {5'd0, 5'd0};
        rd_regdata = {32'h77, 32'h77};
        #1;
        check("zero_in", rd_data[31:0], 32'h0);
`ifdef WB_FWD_PIPE_STATS_EN
        hits_before = fwd_hits;
`endif
        tick();
`ifdef WB_FWD_PIPE_STATS_EN
        check("zero_hits", fwd_hits, hits_before);
`endif
        set_in(1'b0, '0, '0, 1'b0);
        check("zero_st0", rd_data[63:32], 32'h0);
        tick();
        check_wb("zero_wb", 1'b1, 5'd0, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of traffic clears wb_* before the next edge.
        set_in(1'b1, 5'd6, 32'h66, 1'b0);
        tick();
        tick();
        check("pre_rst.we", 32'(bus.wb_we), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_wb("async_rst", 1'b0, 5'd0, 32'h0);
        set_in(1'b0, '0, '0, 1'b0);
        tick();
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
